// File: rtl/key_debounce_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared types and default timing constants for the multi-key
//               push-button conditioner (50 MHz board defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

  // Per-channel debounce FSM state
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    HELD       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

  // Default cycle counts at 50 MHz
  localparam int unsigned c_DEB_CYCLES_DEF    = 1000000;   // 20 ms
  localparam int unsigned c_LONG_CYCLES_DEF   = 50000000;  // 1 s
  localparam int unsigned c_REPEAT_CYCLES_DEF = 10000000;  // 200 ms
  localparam int unsigned c_CNT_W_DEF         = 26;

endpackage
`default_nettype wire

// File: rtl/key_debounce_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_multi_if
// Description : Key pins in, conditioned per-key level and event pulses out.
//               master = key source / consumer side, slave = conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_multi_if #(
  parameter int unsigned NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] Key;
  logic [NUM_KEYS-1:0] Key_State;
  logic [NUM_KEYS-1:0] Key_P_Flag;
  logic [NUM_KEYS-1:0] Key_R_Flag;
  logic [NUM_KEYS-1:0] Key_L_Flag;
  logic [NUM_KEYS-1:0] Key_Rep_Flag;

  modport master (
    output Key,
    input  Key_State,
    input  Key_P_Flag,
    input  Key_R_Flag,
    input  Key_L_Flag,
    input  Key_Rep_Flag
  );

  modport slave (
    input  Key,
    output Key_State,
    output Key_P_Flag,
    output Key_R_Flag,
    output Key_L_Flag,
    output Key_Rep_Flag
  );

endinterface
`default_nettype wire

// File: rtl/key_debounce_multi_ch.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_ch
// Description : One key channel: 2-FF synchroniser, level-qualified debounce
//               FSM, hold counter with long-press and auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
  import key_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = c_DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = c_LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = c_REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = c_CNT_W_DEF
) (
  input  wire  Clk,
  input  wire  Reset,
  input  wire  i_key,
  output logic o_state,
  output logic o_p_flag,
  output logic o_r_flag,
  output logic o_l_flag,
  output logic o_rep_flag
);

  // Pin level that means "not pressed"; synchroniser resets here so that
  // leaving reset never looks like a press edge.
  localparam logic c_RELEASED_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam bit c_LONG_EN = (LONG_CYCLES != 0);
  localparam bit c_REP_EN  = c_LONG_EN && (REPEAT_CYCLES != 0);

  localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pk;
  logic             w_hold_run;
  key_state_e       r_state;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_long_done;

  // Bring the asynchronous pin into the clock domain
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= c_RELEASED_LVL;
      r_sync2 <= c_RELEASED_LVL;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Polarity-normalised key: 1 = pressed
  assign w_pk = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // Hold counter parks once no further event can fire: never counts with
  // long press disabled, and stops after the long press if repeat is off.
  assign w_hold_run = c_LONG_EN && !(r_long_done && !c_REP_EN);

  // Debounce FSM, counters and registered event pulses
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      o_state     <= 1'b0;
      o_p_flag    <= 1'b0;
      o_r_flag    <= 1'b0;
      o_l_flag    <= 1'b0;
      o_rep_flag  <= 1'b0;
    end else begin
      o_p_flag   <= 1'b0;
      o_r_flag   <= 1'b0;
      o_l_flag   <= 1'b0;
      o_rep_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pk) begin
            r_state   <= PRESS_FILT;
            r_deb_cnt <= '0;
          end
        end
        PRESS_FILT: begin
          if (!w_pk) begin
            // any bounce restarts qualification from scratch
            r_state   <= IDLE;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == c_DEB_LAST) begin
            r_state     <= HELD;
            o_p_flag    <= 1'b1;
            o_state     <= 1'b1;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_ONE;
          end
        end
        HELD: begin
          if (!w_pk) begin
            // hold_cnt freezes so a short glitch does not reset hold timing
            r_state   <= REL_FILT;
            r_deb_cnt <= '0;
          end else if (c_LONG_EN && !r_long_done && (r_hold_cnt == c_LONG_LAST)) begin
            o_l_flag    <= 1'b1;
            r_long_done <= 1'b1;
            r_hold_cnt  <= '0;
          end else if (c_REP_EN && r_long_done && (r_hold_cnt == c_REP_LAST)) begin
            o_rep_flag <= 1'b1;
            r_hold_cnt <= '0;
          end else if (w_hold_run) begin
            r_hold_cnt <= r_hold_cnt + c_ONE;
          end
        end
        REL_FILT: begin
          if (w_pk) begin
            r_state <= HELD;
          end else if (r_deb_cnt == c_DEB_LAST) begin
            r_state  <= IDLE;
            o_r_flag <= 1'b1;
            o_state  <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_multi
// Description : Multi-channel push-button conditioner; one independent
//               debounce channel per key pin.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES    = c_DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = c_LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = c_REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = c_CNT_W_DEF
) (
  input wire                  Clk,
  input wire                  Reset,
  key_debounce_multi_if.slave bus
);

  // One self-contained channel per key
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_key      (bus.Key[gi]),
      .o_state    (bus.Key_State[gi]),
      .o_p_flag   (bus.Key_P_Flag[gi]),
      .o_r_flag   (bus.Key_R_Flag[gi]),
      .o_l_flag   (bus.Key_L_Flag[gi]),
      .o_rep_flag (bus.Key_Rep_Flag[gi])
    );
  end

endmodule
`default_nettype wire
